// File: rtl/l2_bridge_pkg.sv
// ---------------------------------------------------------------------------
// l2_bridge_pkg
// Shared definitions for the L2 request bridge: the default field widths,
// default buffer sizing and the packed request payload that travels from
// the upstream request mux to the L2 port.
//
// Contents:
//   *_DEF localparams : default widths and sizes used as parameter defaults
//   l2_req_t          : packed payload {add, wen, wdata, wtag, be, id, aux}
//   payload_width()   : total payload bits for an arbitrary parameter set
// ---------------------------------------------------------------------------
package l2_bridge_pkg;

  localparam int ID_WIDTH_DEF        = 20;
  localparam int ADDR_WIDTH_DEF      = 32;
  localparam int DATA_WIDTH_DEF      = 32;
  localparam int AUX_WIDTH_DEF       = 6;
  localparam int BE_WIDTH_DEF        = DATA_WIDTH_DEF / 8;
  localparam int TAG_WIDTH_DEF       = DATA_WIDTH_DEF / 8;
  localparam int DEPTH_DEF           = 4;
  localparam int MAX_OUTSTANDING_DEF = 8;

  // Field order here is the bit order used when the top level flattens a
  // request into a FIFO word, so the two must stay in step.
  typedef struct packed {
    logic [ADDR_WIDTH_DEF-1:0] add;
    logic                      wen;
    logic [DATA_WIDTH_DEF-1:0] wdata;
    logic [TAG_WIDTH_DEF-1:0]  wtag;
    logic [BE_WIDTH_DEF-1:0]   be;
    logic [ID_WIDTH_DEF-1:0]   id;
    logic [AUX_WIDTH_DEF-1:0]  aux;
  } l2_req_t;

  // Width of one stored request when the block is built with non-default
  // parameters (the packed typedef only covers the defaults).
  function automatic int payload_width(input int id_w, input int addr_w,
                                       input int data_w, input int tag_w,
                                       input int be_w, input int aux_w);
    return addr_w + 1 + data_w + tag_w + be_w + id_w + aux_w;
  endfunction

endpackage

// File: rtl/l2_req_fifo.sv
// ---------------------------------------------------------------------------
// l2_req_fifo
// DEPTH-entry register-array FIFO holding flattened request words. Pointers
// wrap naturally because DEPTH is a power of two. Only the control flops
// (pointers, count) are reset; the array contents are don't-care and the
// read port is forced to zero whenever the FIFO is empty.
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   push       : write wdata into the tail (ignored while full)
//   pop        : discard the head entry (ignored while empty)
//   wdata      : word to store
//   rdata      : head entry, zero when empty
//   full       : count == DEPTH
//   empty      : count == 0
//   count      : current occupancy
// ---------------------------------------------------------------------------
module l2_req_fifo
  import l2_bridge_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  // Guard both ends locally so the FIFO can never overrun or underrun,
  // whatever the surrounding logic does.
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign rdata = empty ? '0 : mem[rd_ptr];

  // Storage array: written on accepted pushes only, never reset.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointer and occupancy bookkeeping. A simultaneous push and pop moves
  // both pointers and leaves the count alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/l2_req_buffer.sv
// ---------------------------------------------------------------------------
// l2_req_buffer
// Decouples the upstream 2:1 request mux from the L2 port. Requests are
// queued in a small FIFO (no bypass, so a request is seen downstream at the
// earliest one cycle after it was accepted) and forwarded in order. An
// in-flight counter limits how many requests may be waiting for a response
// at the target, and a sticky error flag records responses that arrive when
// nothing is outstanding.
//
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   data_req_i          : upstream request
//   data_*_i            : upstream payload (add, wen, wdata, wtag, be, ID, aux)
//   data_gnt_o          : upstream grant (= FIFO not full)
//   data_req_o          : downstream request (head valid and below the cap)
//   data_*_o            : downstream payload, always the FIFO head
//   data_gnt_i          : downstream grant
//   r_valid_i           : one pulse per completed transaction
//   count_o             : FIFO occupancy
//   outstanding_o       : requests popped but not yet answered
//   err_o               : sticky response-without-request error
// ---------------------------------------------------------------------------
module l2_req_buffer
  import l2_bridge_pkg::*;
#(
  parameter int ID_WIDTH        = ID_WIDTH_DEF,
  parameter int ADDR_WIDTH      = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH      = DATA_WIDTH_DEF,
  parameter int AUX_WIDTH       = AUX_WIDTH_DEF,
  parameter int BE_WIDTH        = DATA_WIDTH / 8,
  parameter int TAG_WIDTH       = DATA_WIDTH / 8,
  parameter int DEPTH           = DEPTH_DEF,
  parameter int MAX_OUTSTANDING = MAX_OUTSTANDING_DEF
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 data_req_i,
  input  logic [ADDR_WIDTH-1:0]                data_add_i,
  input  logic                                 data_wen_i,
  input  logic [DATA_WIDTH-1:0]                data_wdata_i,
  input  logic [TAG_WIDTH-1:0]                 data_wtag_i,
  input  logic [BE_WIDTH-1:0]                  data_be_i,
  input  logic [ID_WIDTH-1:0]                  data_ID_i,
  input  logic [AUX_WIDTH-1:0]                 data_aux_i,
  output logic                                 data_gnt_o,
  output logic                                 data_req_o,
  output logic [ADDR_WIDTH-1:0]                data_add_o,
  output logic                                 data_wen_o,
  output logic [DATA_WIDTH-1:0]                data_wdata_o,
  output logic [TAG_WIDTH-1:0]                 data_wtag_o,
  output logic [BE_WIDTH-1:0]                  data_be_o,
  output logic [ID_WIDTH-1:0]                  data_ID_o,
  output logic [AUX_WIDTH-1:0]                 data_aux_o,
  input  logic                                 data_gnt_i,
  input  logic                                 r_valid_i,
  output logic [$clog2(DEPTH+1)-1:0]           count_o,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o,
  output logic                                 err_o
);

  localparam int PW    = payload_width(ID_WIDTH, ADDR_WIDTH, DATA_WIDTH,
                                       TAG_WIDTH, BE_WIDTH, AUX_WIDTH);
  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

  logic [PW-1:0] fifo_wdata;
  logic [PW-1:0] fifo_rdata;
  logic          fifo_full;
  logic          fifo_empty;
  logic          push;
  logic          pop;
  logic          below_cap;

  // Grant comes purely from FIFO state, so there is no combinational path
  // from data_req_i to data_gnt_o.
  assign data_gnt_o = ~fifo_full;
  assign push       = data_req_i & ~fifo_full;

  assign below_cap  = (outstanding_o < OUT_W'(MAX_OUTSTANDING));
  assign data_req_o = ~fifo_empty & below_cap;
  // A downstream grant without a request is simply not a pop.
  assign pop        = data_req_o & data_gnt_i;

  assign fifo_wdata = {data_add_i, data_wen_i, data_wdata_i, data_wtag_i,
                       data_be_i, data_ID_i, data_aux_i};

  assign {data_add_o, data_wen_o, data_wdata_o, data_wtag_o,
          data_be_o, data_ID_o, data_aux_o} = fifo_rdata;

  l2_req_fifo #(
    .WIDTH (PW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .wdata (fifo_wdata),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (count_o)
  );

  // In-flight tracking: a pop adds one, a response removes one, both in
  // the same cycle cancel. A lone response with nothing in flight is a
  // protocol error; the counter stays at zero and the error sticks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding_o <= '0;
      err_o         <= 1'b0;
    end else begin
      case ({pop, r_valid_i})
        2'b10: outstanding_o <= outstanding_o + OUT_W'(1);
        2'b01: begin
          if (outstanding_o == '0) begin
            err_o <= 1'b1;
          end else begin
            outstanding_o <= outstanding_o - OUT_W'(1);
          end
        end
        default: outstanding_o <= outstanding_o;
      endcase
    end
  end

endmodule

// File: tb/tb_l2_req_buffer.sv
// ---------------------------------------------------------------------------
// tb_l2_req_buffer
// Self-checking bench for l2_req_buffer. A reference model (a queue of
// accepted requests plus an in-flight integer) is advanced once per cycle
// from the handshake rules; a monitor compares every DUT output against it
// on the falling clock edge. Directed phases cover reset, fill, streaming,
// the outstanding cap, the error flag and reset mid-burst, followed by a
// randomized phase.
// ---------------------------------------------------------------------------
module tb_l2_req_buffer;
  import l2_bridge_pkg::*;

  localparam int DEPTH   = DEPTH_DEF;
  localparam int MAX_OUT = MAX_OUTSTANDING_DEF;

  logic    clk;
  logic    rst_n;
  logic    data_req_i;
  l2_req_t req_drv;
  logic    data_gnt_o;
  logic    data_req_o;
  l2_req_t dut_pl;
  logic    data_gnt_i;
  logic    r_valid_i;
  logic [$clog2(DEPTH+1)-1:0]   count_o;
  logic [$clog2(MAX_OUT+1)-1:0] outstanding_o;
  logic    err_o;

  logic [ADDR_WIDTH_DEF-1:0] data_add_o;
  logic                      data_wen_o;
  logic [DATA_WIDTH_DEF-1:0] data_wdata_o;
  logic [TAG_WIDTH_DEF-1:0]  data_wtag_o;
  logic [BE_WIDTH_DEF-1:0]   data_be_o;
  logic [ID_WIDTH_DEF-1:0]   data_ID_o;
  logic [AUX_WIDTH_DEF-1:0]  data_aux_o;

  assign dut_pl = {data_add_o, data_wen_o, data_wdata_o, data_wtag_o,
                   data_be_o, data_ID_o, data_aux_o};

  int assertions = 0;
  int failures   = 0;

  // Reference model state
  l2_req_t exp_q[$];
  int      exp_out = 0;
  bit      exp_err = 0;
  bit      pop_seen = 0;

  // Phase markers maintained by the monitor
  int cycle = 0;
  int pops_total = 0;
  int first_pop = -1;
  int last_pop = -1;
  int first_push = -1;
  int last_push = -1;
  int max_out = 0;

  bit auto_resp = 0;
  bit rand_gnt  = 0;

  l2_req_buffer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .data_req_i    (data_req_i),
    .data_add_i    (req_drv.add),
    .data_wen_i    (req_drv.wen),
    .data_wdata_i  (req_drv.wdata),
    .data_wtag_i   (req_drv.wtag),
    .data_be_i     (req_drv.be),
    .data_ID_i     (req_drv.id),
    .data_aux_i    (req_drv.aux),
    .data_gnt_o    (data_gnt_o),
    .data_req_o    (data_req_o),
    .data_add_o    (data_add_o),
    .data_wen_o    (data_wen_o),
    .data_wdata_o  (data_wdata_o),
    .data_wtag_o   (data_wtag_o),
    .data_be_o     (data_be_o),
    .data_ID_o     (data_ID_o),
    .data_aux_o    (data_aux_o),
    .data_gnt_i    (data_gnt_i),
    .r_valid_i     (r_valid_i),
    .count_o       (count_o),
    .outstanding_o (outstanding_o),
    .err_o         (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison; every check in the bench goes through here.
  task automatic checkOutput(input string name, input logic [127:0] act,
                             input logic [127:0] exp);
    assertions++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Offer one request (random payload, given address) starting at
  // posedge+1 and hold it until it is accepted; returns at posedge+1.
  task automatic applyStimulus(input logic [31:0] addr);
    bit accepted = 0;
    req_drv.add   = addr;
    req_drv.wen   = 1'($urandom_range(0, 1));
    req_drv.wdata = $urandom;
    req_drv.wtag  = 4'($urandom);
    req_drv.be    = 4'($urandom);
    req_drv.id    = 20'($urandom);
    req_drv.aux   = 6'($urandom);
    data_req_i    = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (data_gnt_o) begin
        accepted = 1;
        break;
      end
    end
    if (!accepted) checkOutput("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    data_req_i = 1'b0;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    r_valid_i = 1'b0;
    data_req_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_gnt"}, data_gnt_o, 1);
    checkOutput({tag, "_req"}, data_req_o, 0);
    checkOutput({tag, "_count"}, count_o, 0);
    checkOutput({tag, "_outstanding"}, outstanding_o, 0);
    checkOutput({tag, "_err"}, err_o, 0);
    checkOutput({tag, "_payload"}, dut_pl, 0);
  endtask

  // Monitor and reference model. Outputs are compared with the model state
  // reached after the previous edge, then the model is advanced using the
  // inputs that the next rising edge will sample.
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      exp_out  = 0;
      exp_err  = 0;
      pop_seen = 0;
    end else begin
      bit exp_req;
      bit push;
      bit pop;
      cycle++;
      exp_req = (exp_q.size() > 0) && (exp_out < MAX_OUT);
      checkOutput("gnt", data_gnt_o, exp_q.size() < DEPTH);
      checkOutput("req", data_req_o, exp_req);
      checkOutput("count", count_o, exp_q.size());
      checkOutput("outstanding", outstanding_o, exp_out);
      checkOutput("err", err_o, exp_err);
      if (exp_q.size() > 0) checkOutput("payload", dut_pl, exp_q[0]);
      else checkOutput("payload_empty", dut_pl, 0);
      if (int'(outstanding_o) > max_out) max_out = int'(outstanding_o);

      push = data_req_i && (exp_q.size() < DEPTH);
      pop  = exp_req && data_gnt_i;
      if (pop) begin
        void'(exp_q.pop_front());
        pops_total++;
        if (first_pop < 0) first_pop = cycle;
        last_pop = cycle;
      end
      if (push) begin
        exp_q.push_back(req_drv);
        if (first_push < 0) first_push = cycle;
        last_push = cycle;
      end
      if (pop && !r_valid_i) exp_out++;
      else if (r_valid_i && !pop) begin
        if (exp_out == 0) exp_err = 1;
        else exp_out--;
      end
      pop_seen = pop;
    end
  end

  // Target model: answers each pop one cycle later while enabled.
  always @(posedge clk) begin
    #1;
    if (auto_resp) r_valid_i = pop_seen;
  end

  // Random downstream back-pressure for the randomized phase.
  always @(posedge clk) begin
    #1;
    if (rand_gnt) data_gnt_i = 1'($urandom_range(0, 1));
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int pops_before;
    data_req_i = 1'b0;
    req_drv    = '0;
    data_gnt_i = 1'b0;
    r_valid_i  = 1'b0;
    rst_n      = 1'b0;
    #1;
    checkIdle("reset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    waitCycles(1);
    checkIdle("idle");

    // Fill with the target stalled: four fit, the fifth waits for the
    // first pop and is accepted the cycle after it.
    $display("[TB] fill");
    first_pop = -1;
    pops_before = pops_total;
    applyStimulus(32'h10);
    applyStimulus(32'h20);
    applyStimulus(32'h30);
    applyStimulus(32'h40);
    checkOutput("fill_gnt_low", data_gnt_o, 0);
    checkOutput("fill_count", count_o, 4);
    fork
      applyStimulus(32'h50);
      begin
        @(posedge clk);
        #2 data_gnt_i = 1'b1;
      end
    join
    checkOutput("fill_fifth_after_pop", last_push - first_pop, 1);
    waitCycles(8);
    checkOutput("fill_pops", pops_total - pops_before, 5);
    checkOutput("fill_drained", count_o, 0);

    // Streaming with a responsive target.
    $display("[TB] streaming");
    doReset();
    data_gnt_i = 1'b1;
    auto_resp  = 1;
    first_pop = -1; first_push = -1; max_out = 0;
    pops_before = pops_total;
    for (int i = 0; i < 100; i++) applyStimulus(32'h1000 + 32'(i * 4));
    waitCycles(5);
    checkOutput("stream_pops", pops_total - pops_before, 100);
    checkOutput("stream_latency", first_pop - first_push, 1);
    checkOutput("stream_rate", last_pop - first_pop, 99);
    checkOutput("stream_max_out", max_out, 1);
    auto_resp = 0;
    r_valid_i = 1'b0;

    // Outstanding cap with a silent target.
    $display("[TB] outstanding cap");
    doReset();
    data_gnt_i = 1'b1;
    pops_before = pops_total;
    for (int i = 0; i < 10; i++) applyStimulus(32'h2000 + 32'(i));
    waitCycles(3);
    checkOutput("cap_pops", pops_total - pops_before, MAX_OUT);
    checkOutput("cap_req_low", data_req_o, 0);
    checkOutput("cap_outstanding", outstanding_o, MAX_OUT);
    checkOutput("cap_count", count_o, 2);
    r_valid_i = 1'b1;
    waitCycles(1);
    r_valid_i = 1'b0;
    checkOutput("cap_req_reopen", data_req_o, 1);
    waitCycles(1);
    checkOutput("cap_one_more_pop", pops_total - pops_before, MAX_OUT + 1);
    checkOutput("cap_req_closed", data_req_o, 0);

    // Response with nothing outstanding.
    $display("[TB] error flag");
    doReset();
    r_valid_i = 1'b1;
    waitCycles(1);
    r_valid_i = 1'b0;
    checkOutput("err_set", err_o, 1);
    checkOutput("err_outstanding", outstanding_o, 0);
    waitCycles(5);
    checkOutput("err_sticky", err_o, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("err_cleared", err_o, 0);
    waitCycles(1);
    rst_n = 1'b1;

    // Asynchronous reset with buffered and in-flight requests.
    $display("[TB] reset mid-burst");
    data_gnt_i = 1'b1;
    for (int i = 0; i < 5; i++) applyStimulus(32'h3000 + 32'(i));
    waitCycles(2);
    data_gnt_i = 1'b0;
    for (int i = 0; i < 3; i++) applyStimulus(32'h4000 + 32'(i));
    checkOutput("burst_count", count_o, 3);
    checkOutput("burst_outstanding", outstanding_o, 5);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkIdle("async_reset");
    waitCycles(2);
    rst_n = 1'b1;
    r_valid_i = 1'b1;
    waitCycles(1);
    r_valid_i = 1'b0;
    checkOutput("late_response_err", err_o, 1);

    // Randomized traffic with random back-pressure.
    $display("[TB] random");
    doReset();
    auto_resp = 1;
    rand_gnt  = 1;
    for (int i = 0; i < 150; i++) begin
      int gap = $urandom_range(0, 2);
      if (gap > 0) waitCycles(gap);
      applyStimulus($urandom);
    end
    rand_gnt   = 0;
    data_gnt_i = 1'b1;
    waitCycles(20);
    checkOutput("random_drained", count_o, 0);
    checkOutput("random_outstanding", outstanding_o, 0);
    checkOutput("random_err", err_o, 0);
    auto_resp = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
